// File: rtl/instr_fetch_r32_pkg.sv
`default_nettype none
// ============================================================================
//  Package    : fetch_pkg
//  Description: Shared types and constants for the RV32 instruction-fetch
//               front end (state encoding, pipeline distance, word size).
//  Revision   : 1.0  initial release
// ============================================================================
package fetch_pkg;

    // Fetch control states
    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_HALT  = 2'd2
    } fetch_state_t;

    // Fetch-to-execute distance already subtracted from relative jump offsets
    localparam int unsigned PIPELINE_STAGES = 2;

    // Bytes per instruction word
    localparam int unsigned WORD_BYTES = 4;

    // Canonical no-op (addi x0, x0, 0)
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // True when the two address LSBs describe a word-aligned target
    function automatic logic is_word_aligned(input logic [1:0] lsbs);
        return (lsbs == 2'b00);
    endfunction

endpackage
`default_nettype wire

// File: rtl/instr_fetch_r32_if.sv
`default_nettype none
// ============================================================================
//  Interface  : instr_fetch_r32_if
//  Description: Instruction-memory request/response bus plus the execute-side
//               instruction handshake and redirect inputs of the fetch unit.
//  Revision   : 1.0  initial release
// ============================================================================
interface instr_fetch_r32_if #(
    parameter int INSTR_LENGTH = 32
);
    // Instruction memory side
    logic                    imem_req_valid;
    logic                    imem_req_ready;
    logic [INSTR_LENGTH-1:0] imem_addr;
    logic                    imem_rsp_valid;
    logic [INSTR_LENGTH-1:0] imem_rsp_data;

    // Execute side
    logic                    instr_valid;
    logic                    instr_ready;
    logic [INSTR_LENGTH-1:0] instr;
    logic [INSTR_LENGTH-1:0] instr_pc;
    logic                    pc_jump;
    logic                    not_relative_pc;
    logic [INSTR_LENGTH-1:0] jump_offset;
    logic                    exec_err;

    // Status
    logic                    halted;
    logic                    fetch_err;

    // Fetch unit view
    modport master (
        output imem_req_valid, imem_addr,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
        output instr_valid, instr, instr_pc,
        input  instr_ready, pc_jump, not_relative_pc, jump_offset, exec_err,
        output halted, fetch_err
    );

    // Memory / execute / environment view
    modport slave (
        input  imem_req_valid, imem_addr,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
        input  instr_valid, instr, instr_pc,
        output instr_ready, pc_jump, not_relative_pc, jump_offset, exec_err,
        input  halted, fetch_err
    );

endinterface
`default_nettype wire

// File: rtl/instr_fetch_r32_fifo.sv
`default_nettype none
// ============================================================================
//  Module     : fetch_fifo
//  Description: Two-entry {instr, pc} buffer with registered storage, head
//               read straight from the entry flops, and synchronous clear
//               that takes priority over push/pop.
//  Revision   : 1.0  initial release
// ============================================================================
module fetch_fifo #(
    parameter int WIDTH = 64
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_clr,
    input  wire logic             i_push,
    input  wire logic             i_pop,
    input  wire logic [WIDTH-1:0] i_wdata,
    output logic      [WIDTH-1:0] o_rdata,
    output logic                  o_full,
    output logic                  o_empty,
    output logic      [1:0]       o_count
);

    logic [WIDTH-1:0] mem_q [2];
    logic [WIDTH-1:0] mem_d [2];
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [1:0]       count_q,  count_d;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_rdata = mem_q[rd_ptr_q];
    assign o_empty = (count_q == 2'd0);
    assign o_full  = (count_q == 2'd2);
    assign o_count = count_q;

    // Next-state for pointers, occupancy and storage; a full buffer may
    // still accept a push when the head leaves in the same cycle
    always_comb begin
        mem_d[0]  = mem_q[0];
        mem_d[1]  = mem_q[1];
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        w_do_pop  = i_pop && !o_empty;
        w_do_push = i_push && (!o_full || w_do_pop);
        if (i_clr) begin
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            if (w_do_push) begin
                mem_d[wr_ptr_q] = i_wdata;
                wr_ptr_d        = ~wr_ptr_q;
            end
            if (w_do_pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    // Storage and pointer registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q[0] <= mem_d[0];
            mem_q[1] <= mem_d[1];
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/instr_fetch_r32.sv
`default_nettype none
// ============================================================================
//  Module     : instr_fetch_r32
//  Description: RV32 fetch front end. Owns the PC, issues word reads to
//               instruction memory under a two-slot credit scheme, buffers
//               responses and hands {instr, pc} to execute. Consumes the
//               execute stage's redirect / error outputs.
//  Revision   : 1.0  initial release
// ============================================================================
module instr_fetch_r32
    import fetch_pkg::*;
#(
    parameter int                    INSTR_LENGTH = 32,
    parameter logic [INSTR_LENGTH-1:0] RESET_PC   = '0
) (
    input wire logic          clk,
    input wire logic          rst,
    instr_fetch_r32_if.master bus
);

    localparam logic [INSTR_LENGTH-1:0] PC_STEP = INSTR_LENGTH'(WORD_BYTES);
    localparam logic [INSTR_LENGTH-1:0] PC_BIAS = INSTR_LENGTH'(WORD_BYTES * PIPELINE_STAGES);
    localparam int                      FW      = 2 * INSTR_LENGTH;

    fetch_state_t            state_q,       state_d;
    logic [INSTR_LENGTH-1:0] fetch_pc_q,    fetch_pc_d;
    logic [1:0]              outstanding_q, outstanding_d;
    logic [1:0]              drop_cnt_q,    drop_cnt_d;
    logic                    started_q;
    logic                    halted_q,      halted_d;
    logic                    fetch_err_q,   fetch_err_d;

    logic                    w_fifo_push;
    logic                    w_fifo_pop;
    logic                    w_fifo_clr;
    logic                    w_fifo_full;
    logic                    w_fifo_empty;
    logic [1:0]              w_fifo_count;
    logic [FW-1:0]           w_fifo_rdata;

    logic                    w_consume;
    logic                    w_kill;
    logic                    w_credit_ok;
    logic                    w_req_valid;
    logic                    w_req_hs;
    logic                    w_rsp_retire;
    logic [INSTR_LENGTH-1:0] w_target;
    logic [INSTR_LENGTH-1:0] w_rsp_pc;

    fetch_fifo #(
        .WIDTH (FW)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (w_fifo_clr),
        .i_push  (w_fifo_push),
        .i_pop   (w_fifo_pop),
        .i_wdata ({bus.imem_rsp_data, w_rsp_pc}),
        .o_rdata (w_fifo_rdata),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    assign bus.instr_valid                = !w_fifo_empty;
    assign {bus.instr, bus.instr_pc}      = w_fifo_rdata;
    assign bus.imem_addr                  = fetch_pc_q;
    assign bus.imem_req_valid             = w_req_valid;
    assign bus.halted                     = halted_q;
    assign bus.fetch_err                  = fetch_err_q;

    // Handshake decode, redirect target and request gating. A consume cycle
    // frees a slot, so it may fund a new request in the same cycle; any
    // redirect or error on that cycle withholds the request entirely.
    always_comb begin
        w_consume    = !w_fifo_empty && bus.instr_ready;
        w_kill       = w_consume && (bus.pc_jump || bus.exec_err);
        w_credit_ok  = (({1'b0, w_fifo_count} + {1'b0, outstanding_q}) < 3'd2);
        w_req_valid  = started_q && (state_q == ST_RUN) && (w_credit_ok || w_consume) && !w_kill;
        w_req_hs     = w_req_valid && bus.imem_req_ready;
        w_rsp_retire = bus.imem_rsp_valid && (outstanding_q != 2'd0);
        w_target     = bus.not_relative_pc ? bus.jump_offset
                                           : (bus.instr_pc + bus.jump_offset + PC_BIAS);
        // Requests are sequential, so the oldest in-flight address trails
        // the fetch PC by one word per outstanding request
        w_rsp_pc     = fetch_pc_q - INSTR_LENGTH'({outstanding_q, 2'b00});
    end

    // Next-state logic for the RUN / FLUSH / HALT controller
    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        drop_cnt_d    = drop_cnt_q;
        halted_d      = halted_q;
        fetch_err_d   = fetch_err_q;
        w_fifo_push   = 1'b0;
        w_fifo_pop    = 1'b0;
        w_fifo_clr    = 1'b0;

        if (w_req_hs) begin
            fetch_pc_d = fetch_pc_q + PC_STEP;
        end
        case ({w_req_hs, w_rsp_retire})
            2'b10:   outstanding_d = outstanding_q + 2'd1;
            2'b01:   outstanding_d = outstanding_q - 2'd1;
            default: outstanding_d = outstanding_q;
        endcase

        case (state_q)
            ST_RUN: begin
                w_fifo_pop  = w_consume;
                w_fifo_push = bus.imem_rsp_valid && (!w_fifo_full || w_consume);
                if (w_consume && bus.exec_err) begin
                    state_d     = ST_HALT;
                    halted_d    = 1'b1;
                    fetch_err_d = 1'b0;
                    w_fifo_clr  = 1'b1;
                end else if (w_consume && bus.pc_jump) begin
                    w_fifo_clr = 1'b1;
                    if (!is_word_aligned(w_target[1:0])) begin
                        state_d     = ST_HALT;
                        halted_d    = 1'b1;
                        fetch_err_d = 1'b1;
                    end else begin
                        // A response arriving now is already retired above
                        // and therefore not part of the drop count
                        fetch_pc_d = w_target;
                        drop_cnt_d = outstanding_d;
                        state_d    = (outstanding_d != 2'd0) ? ST_FLUSH : ST_RUN;
                    end
                end
            end
            ST_FLUSH: begin
                if (drop_cnt_q == 2'd0) begin
                    state_d = ST_RUN;
                end else if (bus.imem_rsp_valid) begin
                    drop_cnt_d = drop_cnt_q - 2'd1;
                end
            end
            default: begin
                // HALT: everything frozen until reset
            end
        endcase
    end

    // Controller and PC registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_RUN;
            fetch_pc_q    <= RESET_PC;
            outstanding_q <= 2'd0;
            drop_cnt_q    <= 2'd0;
            started_q     <= 1'b0;
            halted_q      <= 1'b0;
            fetch_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
            started_q     <= 1'b1;
            halted_q      <= halted_d;
            fetch_err_q   <= fetch_err_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_r32.sv
`default_nettype none
// ============================================================================
//  Module     : tb_instr_fetch_r32
//  Description: Self-checking bench for instr_fetch_r32. An in-order memory
//               model with random latency/ready feeds the DUT; a program-order
//               model predicts each consumed {pc, instr}, each request address
//               and the halt status from the architectural fetch rules.
//  Revision   : 1.0  initial release
// ============================================================================
module tb_instr_fetch_r32;

    localparam int          IL     = 32;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic clk;
    logic rst;

    instr_fetch_r32_if #(.INSTR_LENGTH(IL)) bus ();

    instr_fetch_r32 #(
        .INSTR_LENGTH (IL),
        .RESET_PC     (RST_PC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    mreq_t       mq[$];
    int          consume_cyc[$];
    logic [31:0] hs_addrs[$];

    int          total;
    int          bad;
    int          cyc;

    logic [31:0] exp_pc;
    logic [31:0] exp_req;
    logic        exp_halted;
    logic        exp_ferr;

    int ready_pct, iready_pct, min_lat, max_lat, jump_pct, err_pct, misalign_pct;
    int iready_force;
    bit stop_now;

    bit          use_script;
    int          scr_n, scr_idx;
    logic [31:0] scr_pc  [4];
    logic [31:0] scr_off [4];
    bit          scr_nr  [4];
    bit          scr_err [4];
    bit          scr_stop[4];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h want=0x%08h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic add_scr(input logic [31:0] pc, input bit nr, input logic [31:0] off,
                           input bit err, input bit stop);
        scr_pc[scr_n]   = pc;
        scr_nr[scr_n]   = nr;
        scr_off[scr_n]  = off;
        scr_err[scr_n]  = err;
        scr_stop[scr_n] = stop;
        scr_n++;
    endtask

    // Drive all DUT inputs for the current cycle (called just after posedge)
    task automatic drive();
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_data  = mem_word(mq[0].addr);
        end
        bus.imem_req_ready = ($urandom_range(0, 99) < ready_pct);
        if (iready_force >= 0) bus.instr_ready = iready_force[0];
        else                   bus.instr_ready = ($urandom_range(0, 99) < iready_pct);
        bus.pc_jump         = 1'b0;
        bus.not_relative_pc = 1'b0;
        bus.jump_offset     = '0;
        bus.exec_err        = 1'b0;
        if (bus.instr_valid && bus.instr_ready) begin
            if (use_script) begin
                if (scr_idx < scr_n && bus.instr_pc == scr_pc[scr_idx]) begin
                    bus.pc_jump         = 1'b1;
                    bus.not_relative_pc = scr_nr[scr_idx];
                    bus.jump_offset     = scr_off[scr_idx];
                    bus.exec_err        = scr_err[scr_idx];
                    if (scr_stop[scr_idx]) stop_now = 1'b1;
                    scr_idx++;
                end
            end else begin
                if ($urandom_range(0, 99) < jump_pct) begin
                    bus.pc_jump         = 1'b1;
                    bus.not_relative_pc = $urandom_range(0, 1) != 0;
                    if (bus.not_relative_pc)
                        bus.jump_offset = 32'($urandom_range(0, 63)) * 32'd4;
                    else
                        bus.jump_offset = 32'($urandom_range(0, 40)) * 32'd4 - 32'd8;
                    if ($urandom_range(0, 99) < misalign_pct)
                        bus.jump_offset = bus.jump_offset | 32'd2;
                end
                if ($urandom_range(0, 99) < err_pct) bus.exec_err = 1'b1;
            end
        end
    endtask

    // Compare against the model and advance it (called at negedge)
    task automatic sample();
        logic [31:0] tgt;
        chk("halted", bus.halted, exp_halted);
        chk("fetch_err", bus.fetch_err, exp_ferr);
        if (exp_halted) begin
            chk("req_valid_in_halt", bus.imem_req_valid, 1'b0);
            chk("instr_valid_in_halt", bus.instr_valid, 1'b0);
        end
        if (bus.imem_req_valid && bus.imem_req_ready) begin
            chk("imem_addr", bus.imem_addr, exp_req);
            hs_addrs.push_back(bus.imem_addr);
            exp_req = exp_req + 32'd4;
            mq.push_back('{addr: bus.imem_addr, due: cyc + int'($urandom_range(min_lat, max_lat))});
        end
        if (bus.imem_rsp_valid) mq.delete(0);
        chk("inflight_le2", 32'(mq.size() <= 2), 32'd1);
        if (bus.instr_valid && bus.instr_ready) begin
            chk("instr_pc", bus.instr_pc, exp_pc);
            chk("instr", bus.instr, mem_word(exp_pc));
            consume_cyc.push_back(cyc);
            if (bus.exec_err) begin
                exp_halted = 1'b1;
                exp_ferr   = 1'b0;
            end else if (bus.pc_jump) begin
                tgt = bus.not_relative_pc ? bus.jump_offset : (exp_pc + bus.jump_offset + 32'd8);
                if (tgt[1:0] != 2'b00) begin
                    exp_halted = 1'b1;
                    exp_ferr   = 1'b1;
                end else begin
                    exp_pc  = tgt;
                    exp_req = tgt;
                end
            end else begin
                exp_pc = exp_pc + 32'd4;
            end
        end
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n && !stop_now; i++) begin
            drive();
            @(negedge clk);
            sample();
            @(posedge clk);
            cyc++;
            #1;
        end
    endtask

    // Asynchronous reset mid-cycle; memory is reset together with fetch
    task automatic do_reset();
        #1;
        rst = 1'b0;
        mq.delete();
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        bus.imem_req_ready = 1'b0;
        bus.instr_ready    = 1'b0;
        bus.pc_jump        = 1'b0;
        bus.not_relative_pc = 1'b0;
        bus.jump_offset    = '0;
        bus.exec_err       = 1'b0;
        #1;
        chk("rst_req_valid", bus.imem_req_valid, 1'b0);
        chk("rst_imem_addr", bus.imem_addr, RST_PC);
        chk("rst_instr_valid", bus.instr_valid, 1'b0);
        chk("rst_instr", bus.instr, 32'h0);
        chk("rst_instr_pc", bus.instr_pc, 32'h0);
        chk("rst_halted", bus.halted, 1'b0);
        chk("rst_fetch_err", bus.fetch_err, 1'b0);
        exp_pc     = RST_PC;
        exp_req    = RST_PC;
        exp_halted = 1'b0;
        exp_ferr   = 1'b0;
        scr_idx    = 0;
        stop_now   = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        chk("no_req_before_first_edge", bus.imem_req_valid, 1'b0);
        @(posedge clk);
        cyc++;
        #1;
        chk("first_req_after_release", bus.imem_req_valid, 1'b1);
    endtask

    task automatic set_knobs(input int rdy, input int irdy, input int lmin, input int lmax,
                             input int jp, input int ep, input int mp);
        ready_pct    = rdy;
        iready_pct   = irdy;
        min_lat      = lmin;
        max_lat      = lmax;
        jump_pct     = jp;
        err_pct      = ep;
        misalign_pct = mp;
        iready_force = -1;
    endtask

    initial begin
        bit seen_30;
        bit seen_100;
        total      = 0;
        bad        = 0;
        cyc        = 0;
        rst        = 1'b0;
        use_script = 1'b0;
        scr_n      = 0;
        set_knobs(100, 100, 1, 1, 0, 0, 0);
        @(posedge clk);
        #1;

        // Streaming at full rate from reset
        do_reset();
        consume_cyc.delete();
        run_cycles(16);
        chk("consume_count_ge6", 32'(consume_cyc.size() >= 6), 32'd1);
        if (consume_cyc.size() >= 6) begin
            for (int k = 1; k < 6; k++)
                chk("one_per_cycle", 32'(consume_cyc[k] - consume_cyc[k-1]), 32'd1);
        end

        // Execute stalls for 5 cycles: buffer fills, requests stop, no loss
        iready_force = 0;
        run_cycles(5);
        chk("no_req_when_full", bus.imem_req_valid, 1'b0);
        chk("buffer_holds_instr", bus.instr_valid, 1'b1);
        iready_force = -1;
        run_cycles(10);

        // Relative branch, absolute jump, then misaligned absolute target
        set_knobs(100, 100, 1, 2, 0, 0, 0);
        use_script = 1'b1;
        scr_n      = 0;
        add_scr(32'h10,  1'b0, 32'h18,  1'b0, 1'b0);
        add_scr(32'h34,  1'b1, 32'h100, 1'b0, 1'b0);
        add_scr(32'h104, 1'b1, 32'h102, 1'b0, 1'b0);
        do_reset();
        hs_addrs.delete();
        run_cycles(60);
        seen_30  = 1'b0;
        seen_100 = 1'b0;
        foreach (hs_addrs[k]) begin
            if (hs_addrs[k] == 32'h30)  seen_30  = 1'b1;
            if (hs_addrs[k] == 32'h100) seen_100 = 1'b1;
        end
        chk("req_0x30_issued", seen_30, 1'b1);
        chk("req_0x100_issued", seen_100, 1'b1);
        chk("misalign_halted", bus.halted, 1'b1);
        chk("misalign_fetch_err", bus.fetch_err, 1'b1);

        // exec_err together with pc_jump: halt without fetch_err
        scr_n = 0;
        add_scr(32'h8, 1'b0, 32'h40, 1'b1, 1'b0);
        do_reset();
        run_cycles(30);
        chk("exec_err_halted", bus.halted, 1'b1);
        chk("exec_err_fetch_err", bus.fetch_err, 1'b0);

        // Async reset while dropping in-flight responses after a redirect
        set_knobs(100, 100, 3, 3, 0, 0, 0);
        scr_n = 0;
        add_scr(32'h10, 1'b0, 32'h18, 1'b0, 1'b1);
        do_reset();
        run_cycles(60);
        chk("redirect_reached", stop_now, 1'b1);
        use_script = 1'b0;
        set_knobs(100, 100, 1, 2, 0, 0, 0);
        do_reset();
        run_cycles(20);

        // Randomized episodes
        for (int ep = 0; ep < 6; ep++) begin
            if (ep < 3) set_knobs(70, 70, 1, 3, 12, 0, 0);
            else        set_knobs(75, 65, 1, 3, 10, 1, 15);
            do_reset();
            run_cycles(400);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
